ledsd_scanner: RTL and testbench

- Upstream feeder for the LED seven-segment digit serializer.
- Holds a double-buffered register file of up to 8 display digits and decodes each digit to a seven-segment pattern.
- Scans the digits one per `fill` pulse and presents a stable 16-bit {segments, digit-select} word on `data`.
- Provides an atomic frame-boundary commit and per-digit blinking.

---
 rtl/ledsd_scanner.sv | 152 +++++++++++++++
 tb/tb_ledsd_scanner.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ledsd_scanner.sv
// -----------------------------------------------------------------------------
// ledsd_scanner
//
// Upstream feeder for the LED seven-segment digit serializer. Holds a
// double-buffered digit register file (shadow written by the host, active
// scanned to the display). Each fill pulse loads one {segments, select}
// word onto data and advances the scan index. Host updates are copied from
// shadow to active atomically at a frame boundary, so a frame never shows a
// mix of old and new digits. Digits can be blinked individually.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-high reset, clears all state
//   fill           one-cycle pulse; serializer samples data on the same edge
//   wr_en          shadow write strobe
//   wr_addr        shadow digit index (indices >= DIGITS are ignored)
//   wr_data        [5] blank, [4] dp, [3:0] hex value
//   commit         request a shadow->active copy at the next frame boundary
//   blink_mask     bit i = 1 makes digit i blink
//   commit_pending high from a commit request until the copy is done
//   frame_start    one-cycle pulse after digit 0's word has been loaded
//   data           [15:8] segments {a,b,c,d,e,f,g,dp}, [7:0] one-hot select
// -----------------------------------------------------------------------------
module ledsd_scanner #(
   parameter int DIGITS         = 8,
   parameter int BLINK_FRAMES   = 64,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int SEL_ACTIVE_LOW = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fill,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [5:0]  wr_data,
   input  logic        commit,
   input  logic [7:0]  blink_mask,
   output logic        commit_pending,
   output logic        frame_start,
   output logic [15:0] data
);

   localparam int              CNT_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [2:0]      LAST_IDX    = 3'(DIGITS - 1);
   localparam logic [3:0]      NUM_DIGITS  = 4'(DIGITS);
   localparam logic [7:0]      SEG_POL     = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [7:0]      SEL_POL     = (SEL_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [15:0]     POL_MASK    = {SEG_POL, SEL_POL};
   // All segments and all selects inactive, after polarity.
   localparam logic [15:0]     BLANK_WORD  = POL_MASK;
   localparam logic [5:0]      BLANK_ENTRY = 6'h20;

   // Active-high hex decode, bit 7 = a ... bit 1 = g, bit 0 = dp (left clear).
   function automatic logic [7:0] hex_decode(input logic [3:0] value);
      logic [7:0] seg;
      case (value)
         4'h0:    seg = 8'hFC;
         4'h1:    seg = 8'h60;
         4'h2:    seg = 8'hDA;
         4'h3:    seg = 8'hF2;
         4'h4:    seg = 8'h66;
         4'h5:    seg = 8'hB6;
         4'h6:    seg = 8'hBE;
         4'h7:    seg = 8'hE0;
         4'h8:    seg = 8'hFE;
         4'h9:    seg = 8'hF6;
         4'hA:    seg = 8'hEE;
         4'hB:    seg = 8'h3E;
         4'hC:    seg = 8'h9C;
         4'hD:    seg = 8'h7A;
         4'hE:    seg = 8'h9E;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

   // Builds the output word for one digit. A blanked or hidden digit still
   // drives its select line so the serializer timing stays uniform.
   function automatic logic [15:0] encode_word(input logic [5:0] entry,
                                               input logic [2:0] digit,
                                               input logic       hide);
      logic [7:0] seg;
      logic [7:0] sel;
      sel = 8'b1 << digit;
      if (entry[5] || hide)
         seg = 8'h00;
      else
         seg = hex_decode(entry[3:0]) | {7'b0, entry[4]};
      return {seg, sel} ^ POL_MASK;
   endfunction

   logic [5:0]       shadow [8];
   logic [5:0]       active [8];
   logic [2:0]       idx;
   logic [CNT_W-1:0] frame_cnt;
   logic             blink_hidden;

   logic             wr_ok;
   logic             boundary;
   logic             hide_now;

   assign wr_ok    = wr_en && ({1'b0, wr_addr} < NUM_DIGITS);
   // The edge that loads the last digit closes the frame.
   assign boundary = fill && (idx == LAST_IDX);
   assign hide_now = blink_hidden && blink_mask[idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            shadow[i] <= BLANK_ENTRY;
            active[i] <= BLANK_ENTRY;
         end
         idx            <= '0;
         frame_cnt      <= '0;
         blink_hidden   <= 1'b0;
         commit_pending <= 1'b0;
         frame_start    <= 1'b0;
         data           <= BLANK_WORD;
      end else begin
         frame_start <= fill && (idx == 3'd0);

         if (fill) begin
            data <= encode_word(active[idx], idx, hide_now);
            idx  <= boundary ? 3'd0 : idx + 3'd1;
         end

         if (boundary) begin
            if (frame_cnt == CNT_LAST) begin
               frame_cnt    <= '0;
               blink_hidden <= ~blink_hidden;
            end else begin
               frame_cnt <= frame_cnt + CNT_W'(1);
            end
         end

         // The copy reads shadow before this edge's write lands, so a
         // same-edge write waits for the following commit.
         if (boundary && commit_pending) begin
            for (int i = 0; i < 8; i++)
               active[i] <= shadow[i];
            commit_pending <= 1'b0;
         end else if (commit) begin
            commit_pending <= 1'b1;
         end

         if (wr_ok)
            shadow[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_ledsd_scanner.sv
// -----------------------------------------------------------------------------
// tb_ledsd_scanner
//
// Drives three scanner instances with shared stimulus: default parameters,
// a short blink period, and inverted output polarity. A reference model of
// the register file, scan position, completed-frame count and pending flag
// predicts each instance's output word.
// -----------------------------------------------------------------------------
module tb_ledsd_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic        fill;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [5:0]  wr_data;
   logic        commit;
   logic [7:0]  blink_mask;

   logic        pend_a, pend_b, pend_c;
   logic        fs_a, fs_b, fs_c;
   logic [15:0] data_a, data_b, data_c;

   int passed = 0;
   int total  = 0;

   // Reference model state
   logic [5:0]  m_shadow [8];
   logic [5:0]  m_active [8];
   int          m_idx;
   int          m_frames;
   bit          m_pend;
   bit          m_fs;
   logic [15:0] m_data [3];

   int          cfg_bf  [3] = '{64, 2, 64};
   logic [15:0] cfg_pol [3] = '{16'h0000, 16'h0000, 16'hFFFF};

   always #5 clk = ~clk;

   ledsd_scanner #(.DIGITS(8), .BLINK_FRAMES(64), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) dut_a (
      .clk(clk), .reset(reset), .fill(fill), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .commit(commit), .blink_mask(blink_mask),
      .commit_pending(pend_a), .frame_start(fs_a), .data(data_a));

   ledsd_scanner #(.DIGITS(8), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) dut_b (
      .clk(clk), .reset(reset), .fill(fill), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .commit(commit), .blink_mask(blink_mask),
      .commit_pending(pend_b), .frame_start(fs_b), .data(data_b));

   ledsd_scanner #(.DIGITS(8), .BLINK_FRAMES(64), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_c (
      .clk(clk), .reset(reset), .fill(fill), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .commit(commit), .blink_mask(blink_mask),
      .commit_pending(pend_c), .frame_start(fs_c), .data(data_c));

   function automatic logic [7:0] seg_of(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'h0: s = 8'hFC;  4'h1: s = 8'h60;  4'h2: s = 8'hDA;  4'h3: s = 8'hF2;
         4'h4: s = 8'h66;  4'h5: s = 8'hB6;  4'h6: s = 8'hBE;  4'h7: s = 8'hE0;
         4'h8: s = 8'hFE;  4'h9: s = 8'hF6;  4'hA: s = 8'hEE;  4'hB: s = 8'h3E;
         4'hC: s = 8'h9C;  4'hD: s = 8'h7A;  4'hE: s = 8'h9E;  default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Blink phase follows from how many whole frames have been scanned:
   // it flips once every BLINK_FRAMES frames.
   function automatic logic [15:0] exp_word(input int cfg, input logic [5:0] e,
                                            input int i, input int frames,
                                            input logic [7:0] mask);
      bit         hide;
      logic [7:0] seg;
      logic [7:0] sel;
      hide = mask[i] && (((frames / cfg_bf[cfg]) % 2) == 1);
      seg  = (e[5] || hide) ? 8'h00 : (seg_of(e[3:0]) | {7'b0, e[4]});
      sel  = 8'(1 << i);
      return {seg, sel} ^ cfg_pol[cfg];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_shadow[i] = 6'h20;
         m_active[i] = 6'h20;
      end
      m_idx    = 0;
      m_frames = 0;
      m_pend   = 0;
      m_fs     = 0;
      for (int c = 0; c < 3; c++) m_data[c] = cfg_pol[c];
   endtask

   // One clock: apply inputs, step the model at the edge, settle 1 time unit.
   task automatic tick(input bit f, input bit we, input logic [2:0] a,
                       input logic [5:0] d, input bit c);
      bit bnd;
      fill = f; wr_en = we; wr_addr = a; wr_data = d; commit = c;
      @(posedge clk);
      m_fs = f && (m_idx == 0);
      bnd  = f && (m_idx == 7);
      if (f) begin
         for (int k = 0; k < 3; k++)
            m_data[k] = exp_word(k, m_active[m_idx], m_idx, m_frames, blink_mask);
         m_idx = (m_idx + 1) % 8;
         if (bnd) m_frames++;
      end
      if (bnd && m_pend) begin
         m_active = m_shadow;
         m_pend   = 0;
      end else if (c) begin
         m_pend = 1;
      end
      if (we) m_shadow[a] = d;
      #1;
      fill = 0; wr_en = 0; commit = 0;
   endtask

   task automatic align();
      while (m_idx != 0) tick(1, 0, 3'd0, 6'd0, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (data_a !== 16'h0000) $display("FAIL reset_data_a: got %h expected 0000", data_a); else passed++;
      total++; if (data_b !== 16'h0000) $display("FAIL reset_data_b: got %h expected 0000", data_b); else passed++;
      total++; if (data_c !== 16'hFFFF) $display("FAIL reset_data_c: got %h expected FFFF", data_c); else passed++;
      total++; if (pend_a !== 1'b0) $display("FAIL reset_pending: got %b expected 0", pend_a); else passed++;
      total++; if (fs_a !== 1'b0) $display("FAIL reset_frame_start: got %b expected 0", fs_a); else passed++;
   endtask

   task automatic test_scan_blank();
      logic [15:0] lit [3];
      lit[0] = 16'h0001; lit[1] = 16'h0002; lit[2] = 16'h0004;
      for (int k = 0; k < 3; k++) begin
         tick(1, 0, 3'd0, 6'd0, 0);
         total++; if (data_a !== lit[k]) $display("FAIL scan_blank k=%0d: got %h expected %h", k, data_a, lit[k]); else passed++;
         total++; if (fs_a !== m_fs) $display("FAIL scan_frame_start k=%0d: got %b expected %b", k, fs_a, m_fs); else passed++;
         tick(0, 0, 3'd0, 6'd0, 0);
         total++; if (data_a !== lit[k]) $display("FAIL scan_hold k=%0d: got %h expected %h", k, data_a, lit[k]); else passed++;
         total++; if (fs_a !== 1'b0) $display("FAIL scan_fs_low k=%0d: got %b expected 0", k, fs_a); else passed++;
      end
   endtask

   task automatic test_commit();
      int i;
      align();
      tick(0, 1, 3'd0, 6'h00, 0);
      tick(0, 1, 3'd1, 6'h11, 0);
      tick(0, 0, 3'd0, 6'd0, 1);
      total++; if (pend_a !== 1'b1) $display("FAIL commit_pending_set: got %b expected 1", pend_a); else passed++;
      for (int k = 0; k < 16; k++) begin
         i = m_idx;
         tick(1, 0, 3'd0, 6'd0, 0);
         total++; if (data_a !== m_data[0]) $display("FAIL commit_word k=%0d: got %h expected %h", k, data_a, m_data[0]); else passed++;
         total++; if (pend_a !== m_pend) $display("FAIL commit_pending k=%0d: got %b expected %b", k, pend_a, m_pend); else passed++;
         if (k == 7) begin
            total++; if (pend_a !== 1'b0) $display("FAIL commit_clear_at_boundary: got %b expected 0", pend_a); else passed++;
         end
         if (k >= 8 && i == 0) begin
            total++; if (data_a !== 16'hFC01) $display("FAIL commit_digit0: got %h expected FC01", data_a); else passed++;
         end
         if (k >= 8 && i == 1) begin
            total++; if (data_a !== 16'h6102) $display("FAIL commit_digit1: got %h expected 6102", data_a); else passed++;
         end
      end
   endtask

   task automatic test_shadow_hold();
      int i;
      align();
      tick(0, 1, 3'd3, 6'h08, 0);
      for (int k = 0; k < 24; k++) begin
         i = m_idx;
         tick(1, 0, 3'd0, 6'd0, 0);
         total++; if (data_a !== m_data[0]) $display("FAIL hold_word k=%0d: got %h expected %h", k, data_a, m_data[0]); else passed++;
         if (i == 3) begin
            total++; if (data_a !== 16'h0008) $display("FAIL hold_digit3 k=%0d: got %h expected 0008", k, data_a); else passed++;
         end
      end
      tick(0, 0, 3'd0, 6'd0, 1);
      for (int k = 0; k < 16; k++) begin
         i = m_idx;
         tick(1, 0, 3'd0, 6'd0, 0);
         total++; if (data_a !== m_data[0]) $display("FAIL hold_commit_word k=%0d: got %h expected %h", k, data_a, m_data[0]); else passed++;
         if (k >= 8 && i == 3) begin
            total++; if (data_a !== 16'hFE08) $display("FAIL hold_digit3_committed: got %h expected FE08", data_a); else passed++;
         end
      end
   endtask

   task automatic test_blink();
      int i;
      int nv = 0, nh = 0, nbad = 0;
      align();
      tick(0, 1, 3'd2, 6'h0A, 1);
      repeat (8) tick(1, 0, 3'd0, 6'd0, 0);
      blink_mask = 8'h04;
      for (int k = 0; k < 64; k++) begin
         i = m_idx;
         tick(1, 0, 3'd0, 6'd0, 0);
         total++; if (data_b !== m_data[1]) $display("FAIL blink_word_b k=%0d: got %h expected %h", k, data_b, m_data[1]); else passed++;
         total++; if (data_a !== m_data[0]) $display("FAIL blink_word_a k=%0d: got %h expected %h", k, data_a, m_data[0]); else passed++;
         if (i == 2) begin
            if (data_b === 16'hEE04) nv++;
            else if (data_b === 16'h0004) nh++;
            else nbad++;
            total++; if (data_a !== 16'hEE04) $display("FAIL blink_a_visible k=%0d: got %h expected EE04", k, data_a); else passed++;
         end
      end
      total++;
      if (nv == 0 || nh == 0 || nbad != 0)
         $display("FAIL blink_alternation: visible=%0d hidden=%0d other=%0d required visible>0 hidden>0 other=0", nv, nh, nbad);
      else passed++;
      blink_mask = 8'h00;
   endtask

   task automatic test_polarity();
      int i;
      align();
      tick(0, 1, 3'd0, 6'h08, 1);
      for (int k = 0; k < 16; k++) begin
         i = m_idx;
         tick(1, 0, 3'd0, 6'd0, 0);
         total++; if (data_c !== m_data[2]) $display("FAIL polarity_word k=%0d: got %h expected %h", k, data_c, m_data[2]); else passed++;
         if (k >= 8 && i == 0) begin
            total++; if (data_c !== 16'h01FE) $display("FAIL polarity_digit0: got %h expected 01FE", data_c); else passed++;
         end
      end
   endtask

   task automatic test_random();
      bit         f, we, c;
      logic [2:0] a;
      logic [5:0] d;
      for (int n = 0; n < 600; n++) begin
         f  = ($urandom_range(0, 2) == 0);
         we = ($urandom_range(0, 3) == 0);
         c  = ($urandom_range(0, 19) == 0);
         a  = 3'($urandom_range(0, 7));
         d  = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 49) == 0) blink_mask = 8'($urandom_range(0, 255));
         tick(f, we, a, d, c);
         total++; if (data_a !== m_data[0]) $display("FAIL rand_data_a n=%0d: got %h expected %h", n, data_a, m_data[0]); else passed++;
         total++; if (data_b !== m_data[1]) $display("FAIL rand_data_b n=%0d: got %h expected %h", n, data_b, m_data[1]); else passed++;
         total++; if (data_c !== m_data[2]) $display("FAIL rand_data_c n=%0d: got %h expected %h", n, data_c, m_data[2]); else passed++;
         total++;
         if (pend_a !== m_pend || pend_b !== m_pend || pend_c !== m_pend)
            $display("FAIL rand_pending n=%0d: got %b%b%b expected %b", n, pend_a, pend_b, pend_c, m_pend);
         else passed++;
         total++;
         if (fs_a !== m_fs || fs_b !== m_fs || fs_c !== m_fs)
            $display("FAIL rand_frame_start n=%0d: got %b%b%b expected %b", n, fs_a, fs_b, fs_c, m_fs);
         else passed++;
      end
      blink_mask = 8'h00;
   endtask

   task automatic test_mid_reset();
      align();
      repeat (5) tick(1, 0, 3'd0, 6'd0, 0);
      tick(0, 1, 3'd0, 6'h05, 1);
      total++; if (pend_a !== 1'b1) $display("FAIL midreset_pending_before: got %b expected 1", pend_a); else passed++;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      total++; if (data_a !== 16'h0000) $display("FAIL midreset_async_data_a: got %h expected 0000", data_a); else passed++;
      total++; if (data_c !== 16'hFFFF) $display("FAIL midreset_async_data_c: got %h expected FFFF", data_c); else passed++;
      total++; if (pend_a !== 1'b0) $display("FAIL midreset_async_pending: got %b expected 0", pend_a); else passed++;
      @(negedge clk);
      reset = 1'b0;
      tick(1, 0, 3'd0, 6'd0, 0);
      total++; if (data_a !== 16'h0001) $display("FAIL midreset_first_digit: got %h expected 0001", data_a); else passed++;
      total++; if (fs_a !== 1'b1) $display("FAIL midreset_frame_start: got %b expected 1", fs_a); else passed++;
      for (int k = 0; k < 16; k++) begin
         tick(1, 0, 3'd0, 6'd0, 0);
         total++; if (data_a !== m_data[0]) $display("FAIL midreset_word k=%0d: got %h expected %h", k, data_a, m_data[0]); else passed++;
         total++; if (pend_a !== 1'b0) $display("FAIL midreset_pending k=%0d: got %b expected 0", k, pend_a); else passed++;
      end
   endtask

   initial begin
      reset      = 1'b1;
      fill       = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = 3'd0;
      wr_data    = 6'd0;
      commit     = 1'b0;
      blink_mask = 8'h00;
      test_reset();
      test_scan_blank();
      test_commit();
      test_shadow_hold();
      test_blink();
      test_polarity();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
